// File: rtl/exe_mdu.sv
// exe_mdu: single-issue execute unit. One-cycle ALU plus an iterative
// shift-add multiplier and restoring divider that share one accumulator.
module exe_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_hi,
  output logic            div_by_zero,
  output logic            busy
);
  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12, OP_DIV  = 4'd13, OP_DIVU = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN-1);
  localparam logic [SHW:0] CNT_MAX  = (SHW+1)'(XLEN);

  state_t          state_q, state_d;
  logic [SHW:0]    cnt_q, cnt_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d, a_q, a_d;
  logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dbz_q, dbz_d;
  logic [XLEN-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [4:0]      rd_q, rd_d;

  logic            accept, is_mul, is_div, sgn_op, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b, alu_res, it_hi, it_lo, quo, rem;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [SHW-1:0]  shamt;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mul   = (op == OP_MUL) | (op == OP_MULU);
  assign is_div   = (op == OP_DIV) | (op == OP_DIVU);
  assign sgn_op   = (op == OP_MUL) | (op == OP_DIV);
  assign a_neg    = sgn_op & src_a[XLEN-1];
  assign b_neg    = sgn_op & src_b[XLEN-1];
  assign mag_a    = a_neg ? -src_a : src_a;
  assign mag_b    = b_neg ? -src_b : src_b;
  assign shamt    = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration step. MUL shifts the product right through {hi,lo};
  // DIV shifts the dividend out of lo into the partial remainder in hi.
  always_comb begin
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (state_q == S_MUL) begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      it_hi = div_diff[XLEN-1:0];
      it_lo = {acc_lo_q[XLEN-2:0], 1'b1};
    end else begin
      it_hi = div_sh[XLEN-1:0];
      it_lo = {acc_lo_q[XLEN-2:0], 1'b0};
    end
    prod = {it_hi, it_lo};
    if (neg_lo_q) prod = -prod;
    quo = neg_lo_q ? -it_lo : it_lo;
    rem = neg_hi_q ? -it_hi : it_hi;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          cnt_d    = '0;
          rd_d     = rd;
          a_d      = src_a;
          acc_hi_d = '0;
          acc_lo_d = mag_a;
          opnd_d   = mag_b;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          dbz_d    = is_div & (src_b == '0);
          if (is_mul)      state_d = S_MUL;
          else if (is_div) state_d = S_DIV;
          else begin
            res_lo_d = alu_res;
            res_hi_d = '0;
            state_d  = S_DONE;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        acc_hi_d = it_hi;
        acc_lo_d = it_lo;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (state_q == S_MUL) begin
            {res_hi_d, res_lo_d} = prod;
          end else if (dbz_q) begin
            res_lo_d = '1;
            res_hi_d = a_q;
          end else begin
            res_lo_d = quo;
            res_hi_d = rem;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Kill beats both a simultaneous accept and a consumer handshake.
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      rd_q     <= rd_d;
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_MUL) | (state_q == S_DIV);
  assign div_by_zero = dbz_q & out_valid;
  assign out_data    = res_lo_q;
  assign out_hi      = res_hi_q;
  assign out_rd      = rd_q;
endmodule

// File: doc/exe_mdu.md
EXE_MDU -- requirements
Module: exe_mdu

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: an operation is offered.
REQ-006 Port in_ready, output, 1 bit: the unit can accept an operation.
REQ-007 Port op, input, 4 bits: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL, 12 MULU, 13 DIV, 14 DIVU, 15 reserved.
REQ-008 Port src_a, input, XLEN bits: operand A (dividend / shifted value).
REQ-009 Port src_b, input, XLEN bits: operand B (divisor / shift amount in [SHW-1:0]).
REQ-010 Port rd, input, 5 bits: destination register tag.
REQ-011 Port flush, input, 1 bit: synchronous kill of the in-flight operation.
REQ-012 Port out_valid, output, 1 bit: a result is presented.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port out_rd, output, 5 bits: tag of the presented result.
REQ-015 Port out_data, output, XLEN bits: ALU result, product low half, or quotient.
REQ-016 Port out_hi, output, XLEN bits: product high half or remainder; 0 for ALU ops.
REQ-017 Port div_by_zero, output, 1 bit: qualifies out_valid for a DIV/DIVU whose src_b was 0.
REQ-018 Port busy, output, 1 bit: high in the MUL or DIV state.

Function
REQ-019 States: IDLE, MUL, DIV, DONE.
REQ-020 Handshake: in_ready = (state==IDLE) | (state==DONE & out_ready); accept on in_valid & in_ready & ~flush; operands and rd are captured at accept.
REQ-021 Ops 0-10 and 15: the result is registered at accept; next state DONE; out_valid is high the cycle after accept (latency 1).
REQ-022 Op 15 yields out_data=0, out_hi=0.
REQ-023 ALU arithmetic: modulo 2^XLEN; SLT signed, SLTU unsigned, result 1 or 0.
REQ-024 Shifts: SLL/SRL/SRA shift src_a by src_b[SHW-1:0]; SRA is arithmetic.
REQ-025 MUL/MULU:
- iterative shift-add on operand magnitudes, one bit per cycle, XLEN cycles in MUL, then DONE;
- out_valid rises exactly XLEN+1 cycles after accept;
- {out_hi,out_data} = full 2*XLEN-bit product;
- MUL is signed x signed: the product is negated when the operand signs differ.
REQ-026 DIV/DIVU:
- restoring division on magnitudes, XLEN cycles in DIV, then DONE; same latency as REQ-025;
- DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-027 Divide by zero: still takes the full XLEN+1 latency; out_data = all ones; out_hi = src_a; div_by_zero = 1.
REQ-028 Signed overflow (DIV, a = most-negative, b = -1): out_data = most-negative, out_hi = 0, div_by_zero = 0.
REQ-029 DONE holds out_valid and all result outputs stable until out_ready; then go to IDLE, or accept directly per REQ-020 (back-to-back).
REQ-030 flush in any state: next state IDLE, out_valid low the next cycle, result discarded; flush wins over a simultaneous accept and over out_ready.
REQ-031 in_valid while busy: ignored, no state change; the offered op is not captured.
REQ-032 The iteration counter is SHW+1 bits wide and saturates; no wrap past XLEN.

Reset
REQ-033 rst_n low asynchronously forces:
- state = IDLE;
- out_valid, busy, div_by_zero = 0;
- out_data, out_hi = 0; out_rd = 0; counter = 0;
- in_ready = 1 one cycle after release.
REQ-034 Reset mid-MUL/DIV abandons the operation; no result is ever presented for it.

Verification
REQ-035 XLEN=32: ADD 0x7FFFFFFF+1 -> out_data 0x80000000, out_valid one cycle after accept; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-036 MUL -3 x 5 -> out_hi 0xFFFFFFFF, out_data 0xFFFFFFF1, out_valid exactly 33 cycles after accept; MULU 0xFFFFFFFF x 2 -> out_hi 1, out_data 0xFFFFFFFE.
REQ-037 DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, 0; DIVU 9/0 -> 0xFFFFFFFF, 9, div_by_zero 1.
REQ-038 Hold out_ready low for 5 cycles in DONE -> outputs stable, in_ready 0; raise out_ready with in_valid for an AND -> new result on the next cycle, no bubble.
REQ-039 flush at DIV cycle 10 -> IDLE, no out_valid; rst_n low mid-MUL -> all outputs 0 asynchronously; in_valid during busy -> ignored.
REQ-040 Repeat REQ-036 and REQ-037 at XLEN=8 and XLEN=64 with latency XLEN+1.
